// File: rtl/gcd_unit_param.sv
// Iterative GCD engine with a start/busy/done handshake and a saturating iteration counter.
// Define GCD_BINARY_EN to use binary (Stein) reduction instead of subtractive Euclid.
module gcd_unit_param #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             zero_err,
    output logic [CNT_W-1:0] iter_cnt
);

    // Handshake: start is sampled only while busy=0; busy is high exactly while in CALC;
    // done pulses for one cycle with gcd_out/zero_err/iter_cnt valid from that cycle on.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_gcd;
    logic             r_zero_err;
    logic [CNT_W-1:0] r_iter;

    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_gcd_nxt;
    logic             w_zero_err_nxt;
    logic [CNT_W-1:0] w_iter_nxt;

    logic [WIDTH-1:0] w_a_red;
    logic [WIDTH-1:0] w_b_red;
    logic [WIDTH-1:0] w_eq_result;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_a_gt_b;

    assign w_a_gt_b  = (r_a > r_b);
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef GCD_BINARY_EN
    localparam int K_W = $clog2(WIDTH) + 1;

    logic [K_W-1:0] r_k;
    logic [K_W-1:0] w_k_nxt;
    logic [K_W-1:0] w_k_red;

    // The common power of two is stripped into k and restored on equality.
    assign w_eq_result = r_a << r_k;

    always_comb begin
        w_a_red = r_a;
        w_b_red = r_b;
        w_k_red = r_k;
        if (!r_a[0] && !r_b[0]) begin
            w_a_red = r_a >> 1;
            w_b_red = r_b >> 1;
            w_k_red = r_k + K_W'(1);
        end else if (!r_a[0]) begin
            w_a_red = r_a >> 1;
        end else if (!r_b[0]) begin
            w_b_red = r_b >> 1;
        end else if (w_a_gt_b) begin
            w_a_red = r_a - r_b;
        end else begin
            w_b_red = r_b - r_a;
        end
    end
`else
    assign w_eq_result = r_a;

    always_comb begin
        w_a_red = r_a;
        w_b_red = r_b;
        if (w_a_gt_b) begin
            w_a_red = r_a - r_b;
        end else begin
            w_b_red = r_b - r_a;
        end
    end
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_cnt_nxt      = r_cnt;
        w_done_nxt     = 1'b0;
        w_gcd_nxt      = r_gcd;
        w_zero_err_nxt = r_zero_err;
        w_iter_nxt     = r_iter;
`ifdef GCD_BINARY_EN
        w_k_nxt        = r_k;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt     = a_in;
                    w_b_nxt     = b_in;
                    w_cnt_nxt   = '0;
`ifdef GCD_BINARY_EN
                    w_k_nxt     = '0;
`endif
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                // Termination checks are ordered; the first one that holds wins.
                if ((r_a == '0) && (r_b == '0)) begin
                    w_gcd_nxt      = '0;
                    w_zero_err_nxt = 1'b1;
                    w_iter_nxt     = r_cnt;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else if (r_a == '0) begin
                    w_gcd_nxt      = r_b;
                    w_zero_err_nxt = 1'b0;
                    w_iter_nxt     = r_cnt;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else if (r_b == '0) begin
                    w_gcd_nxt      = r_a;
                    w_zero_err_nxt = 1'b0;
                    w_iter_nxt     = r_cnt;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else if (r_a == r_b) begin
                    w_gcd_nxt      = w_eq_result;
                    w_zero_err_nxt = 1'b0;
                    w_iter_nxt     = r_cnt;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_a_nxt   = w_a_red;
                    w_b_nxt   = w_b_red;
                    w_cnt_nxt = w_cnt_inc;
`ifdef GCD_BINARY_EN
                    w_k_nxt   = w_k_red;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_gcd      <= '0;
            r_zero_err <= 1'b0;
            r_iter     <= '0;
`ifdef GCD_BINARY_EN
            r_k        <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_gcd      <= w_gcd_nxt;
            r_zero_err <= w_zero_err_nxt;
            r_iter     <= w_iter_nxt;
`ifdef GCD_BINARY_EN
            r_k        <= w_k_nxt;
`endif
        end
    end

    assign busy     = (r_state == S_CALC);
    assign done     = r_done;
    assign gcd_out  = r_gcd;
    assign zero_err = r_zero_err;
    assign iter_cnt = r_iter;

endmodule

// File: tb/tb_gcd_unit_param.sv
// Scoreboard bench for gcd_unit_param: reference GCD and step-count model, latency and handshake checks.
module tb_gcd_unit_param;

  localparam int W = 16;
  localparam int C = 8;
  localparam int GUARD = 100000;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] gcd_out;
  logic         zero_err;
  logic [C-1:0] iter_cnt;

  gcd_unit_param #(.WIDTH(W), .CNT_W(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .gcd_out  (gcd_out),
    .zero_err (zero_err),
    .iter_cnt (iter_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int model_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int model_steps(input int a, input int b);
    int n = 0;
    while (!(a == 0 || b == 0 || a == b)) begin
`ifdef GCD_BINARY_EN
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
`else
      if (a > b) a = a - b;
      else b = b - a;
`endif
      n++;
    end
    return n;
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         exp_zero_q[$];
  logic [C-1:0] exp_iter_q[$];
  int           exp_lat_q[$];
  int           cap_q[$];

  task automatic push_exp(input int a, input int b, input int cap);
    int steps;
    steps = model_steps(a, b);
    exp_q.push_back(W'(model_gcd(a, b)));
    exp_zero_q.push_back(a == 0 && b == 0);
    exp_iter_q.push_back((steps > (2**C - 1)) ? C'(2**C - 1) : C'(steps));
    exp_lat_q.push_back(steps + 1);
    cap_q.push_back(cap);
  endtask

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (prev_done) check("done_pulse", done, 1'b0);
    prev_done <= done;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        check("gcd_out", gcd_out, exp_q.pop_front());
        check("zero_err", zero_err, exp_zero_q.pop_front());
        check("iter_cnt", iter_cnt, exp_iter_q.pop_front());
        check("latency", cyc - cap_q.pop_front(), exp_lat_q.pop_front());
        check("busy_fall", busy, 1'b0);
      end
    end
  end

  // driver tasks: called and return aligned to a falling edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int g = 0;
    while (busy && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (g >= GUARD) check("idle_timeout", busy, 1'b0);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    if (push) push_exp(int'(a), int'(b), cyc);
    start = 1'b0;
    check("busy_rise", busy, 1'b1);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_gcd"}, gcd_out, '0);
    check({tag, "_zero"}, zero_err, 1'b0);
    check({tag, "_iter"}, iter_cnt, '0);
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    send(16'd143, 16'd78, 1'b1);
    drain();

    // abort mid-calculation
    send(16'd1000, 16'd3, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_done", done, 1'b0);

    send(16'd0, 16'd0, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    check("zero_hold", zero_err, 1'b1);
    send(16'd0, 16'd42, 1'b1);
    send(16'd42, 16'd0, 1'b1);
    drain();

    // start held through busy is ignored, then accepted in the done cycle
    send(16'd48, 16'd18, 1'b1);
    start = 1'b1;
    a_in  = 16'd7;
    b_in  = 16'd7;
    g = 0;
    while (!done && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    check("b2b_done_seen", done, 1'b1);
    @(negedge clk);
    push_exp(7, 7, cyc);
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    drain();

    for (int i = 0; i < 8; i++) begin
      send(W'($urandom_range(1, 300)), W'($urandom_range(1, 300)), 1'b1);
    end
    drain();

    send(16'd65535, 16'd1, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    check("gcd_held", gcd_out, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
